mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arb_ager.sv | 65 ++++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port (fetch/data) single-port memory arbiter.
package mem_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int ADDR_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  typedef enum logic {
    PRI_D = 1'b0,
    PRI_I = 1'b1
  } arb_state_e;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_ager.sv
// Fetch-starvation ager: counts consecutive fetch denials and flips conflict
// priority to the fetch port once the limit is reached.
module mem_arb_ager
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_fetch_priority
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  arb_state_e r_state;
  arb_state_e w_state_next;

  // State and age counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_state <= PRI_D;
    end else begin
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  // Next counter value and priority state
  always_comb begin
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    if (i_gnt) begin
      w_cnt_next = 4'd0;
    end else if (i_req && (r_cnt != LIMIT)) begin
      w_cnt_next = r_cnt + 4'd1;
    end else begin
      w_cnt_next = r_cnt;
    end
    case (r_state)
      PRI_D: begin
        if (w_cnt_next == LIMIT) begin
          w_state_next = PRI_I;
        end else begin
          w_state_next = PRI_D;
        end
      end
      PRI_I: begin
        if (i_gnt) begin
          w_state_next = PRI_D;
        end else begin
          w_state_next = PRI_I;
        end
      end
      default: w_state_next = PRI_D;
    endcase
  end

  assign o_fetch_priority = (r_state == PRI_I);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// one grant per cycle, with a registered one-cycle-later response.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [1:0]        w_gnt;
  logic              w_fetch_pri;
  logic              w_i_ok;
  logic              w_d_ok;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_i_ack;
  logic              r_d_ack;
  logic              r_i_err;
  logic              r_d_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  mem_arb_ager #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_ager (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_gnt           (i_gnt),
    .o_fetch_priority(w_fetch_pri)
  );

  assign w_i_ok = is_aligned(i_addr[1:0]);
  assign w_d_ok = is_aligned(d_addr[1:0]);

  // Grant selection; ager priority only matters on a conflict
  always_comb begin
    w_gnt = 2'b00;
    if (rst) begin
      w_gnt = 2'b00;
    end else if (i_req && d_req) begin
      if (w_fetch_pri) begin
        w_gnt[PORT_I] = 1'b1;
      end else begin
        w_gnt[PORT_D] = 1'b1;
      end
    end else if (i_req) begin
      w_gnt[PORT_I] = 1'b1;
    end else if (d_req) begin
      w_gnt[PORT_D] = 1'b1;
    end else begin
      w_gnt = 2'b00;
    end
  end

  assign i_gnt = w_gnt[PORT_I];
  assign d_gnt = w_gnt[PORT_D];

  // Memory address follows the granted port, otherwise holds
  always_comb begin
    mem_addr = r_mem_addr;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr = d_addr;
    end else begin
      mem_addr = r_mem_addr;
    end
  end

  assign mem_we      = d_gnt & d_we & w_d_ok;
  assign mem_data_in = d_wdata;

  // Address hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr <= '0;
    end else begin
      r_mem_addr <= mem_addr;
    end
  end

  // Response registers: read data is the pre-write memory word seen at the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= i_gnt;
      r_d_ack <= d_gnt;
      r_i_err <= i_gnt & ~w_i_ok;
      r_d_err <= d_gnt & ~w_d_ok;
      if (i_gnt) begin
        r_i_rdata <= w_i_ok ? mem_data_out : '0;
      end else begin
        r_i_rdata <= r_i_rdata;
      end
      if (d_gnt) begin
        r_d_rdata <= w_d_ok ? mem_data_out : '0;
      end else begin
        r_d_rdata <= r_d_rdata;
      end
    end
  end

  // An ack already registered when reset arrives is dropped in that cycle
  assign i_ack   = r_i_ack & ~rst;
  assign d_ack   = r_d_ack & ~rst;
  assign i_err   = r_i_err & ~rst;
  assign d_err   = r_d_err & ~rst;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a reference memory and a denial-count priority model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_we;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_addr[7:2]];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit rnd);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; bd_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bd_addr = 6'(i);
      bd_data = rnd ? $urandom : 32'(i);
      ref_mem[i] = bd_data;
      next_cycle();
    end
    bd_we = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h0; d_wdata = 32'h55;
    next_cycle(); next_cycle();
    @(negedge clk);
    tests++;
    if ({i_gnt, d_gnt, mem_we, i_ack, d_ack, i_err, d_err} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000000", {i_gnt, d_gnt, mem_we, i_ack, d_ack, i_err, d_err});
    end
    tests++;
    if ({i_rdata, d_rdata, mem_addr} !== 96'd0) begin
      fails++; $display("FAIL reset_data: i_rdata %h d_rdata %h mem_addr %h want 0", i_rdata, d_rdata, mem_addr);
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_fetch_stream();
    for (int k = 0; k < 3; k++) begin
      i_req = 1'b1; i_addr = 32'(4 * k);
      @(negedge clk);
      tests++;
      if ({i_gnt, mem_addr} !== {1'b1, 32'(4 * k)}) begin
        fails++; $display("FAIL fetch_gnt[%0d]: gnt %b addr %h want 1 %h", k, i_gnt, mem_addr, 4 * k);
      end
      if (k > 0) begin
        tests++;
        if ({i_ack, i_rdata} !== {1'b1, 32'(k - 1)}) begin
          fails++; $display("FAIL fetch_data[%0d]: ack %b rdata %h want 1 %h", k, i_ack, i_rdata, k - 1);
        end
      end
      next_cycle();
    end
    i_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({i_ack, i_rdata} !== {1'b1, 32'd2}) begin
      fails++; $display("FAIL fetch_last: ack %b rdata %h want 1 2", i_ack, i_rdata);
    end
    next_cycle();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    tests++;
    if ({d_gnt, mem_we} !== 2'b11) begin
      fails++; $display("FAIL store_gnt: gnt/we %b want 11", {d_gnt, mem_we});
    end
    next_cycle();
    d_we = 1'b0;
    @(negedge clk);
    tests++;
    if ({d_gnt, d_ack, d_err, d_rdata} !== {3'b110, 32'd2}) begin
      fails++; $display("FAIL store_ack: gnt/ack/err %b rdata %h want 110 2", {d_gnt, d_ack, d_err}, d_rdata);
    end
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      fails++; $display("FAIL load_after_store: ack %b rdata %h want 1 deadbeef", d_ack, d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_misaligned();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6; d_wdata = 32'h1234;
    @(negedge clk);
    tests++;
    if ({d_gnt, mem_we} !== 2'b10) begin
      fails++; $display("FAIL misal_we: gnt/we %b want 10", {d_gnt, mem_we});
    end
    next_cycle();
    d_we = 1'b0; d_addr = 32'h4;
    @(negedge clk);
    tests++;
    if ({d_ack, d_err, d_rdata} !== {2'b11, 32'd0}) begin
      fails++; $display("FAIL misal_ack: ack/err %b rdata %h want 11 0", {d_ack, d_err}, d_rdata);
    end
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({d_ack, d_err, d_rdata} !== {2'b10, 32'd1}) begin
      fails++; $display("FAIL misal_old: ack/err %b rdata %h want 10 1", {d_ack, d_err}, d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_conflict();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      tests++;
      if ({i_gnt, d_gnt} !== ((c % 5 == 4) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL conflict[%0d]: i/d gnt %b want %b", c, {i_gnt, d_gnt}, (c % 5 == 4) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_midstream();
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({i_gnt, d_gnt} !== 2'b01) begin
        fails++; $display("FAIL mid_pre[%0d]: i/d gnt %b want 01", c, {i_gnt, d_gnt});
      end
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({d_ack, i_gnt, d_gnt} !== 3'b000) begin
      fails++; $display("FAIL mid_ack_suppress: ack/ig/dg %b want 000", {d_ack, i_gnt, d_gnt});
    end
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({i_gnt, d_gnt} !== ((c % 5 == 4) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL mid_post[%0d]: i/d gnt %b want %b", c, {i_gnt, d_gnt}, (c % 5 == 4) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_random();
    int          denials = 0;
    bit          i_hold = 1'b0, d_hold = 1'b0;
    bit          eg_i, eg_d, e_we;
    bit          e_iack = 1'b0, e_dack = 1'b0, e_ierr = 1'b0, e_derr = 1'b0;
    logic [31:0] e_ird = 32'd0, e_drd = 32'd0, e_addr, last_addr = 32'd0;
    preload(1'b1);
    for (int n = 0; n < 10000; n++) begin
      if (!i_hold) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 32'($urandom_range(0, 63) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
      end
      if (!d_hold) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) != 0;
        d_wdata = $urandom;
        d_addr  = 32'($urandom_range(0, 63) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
      end
      if (i_req && d_req) begin
        eg_i = (denials == LIMIT);
        eg_d = !eg_i;
      end else begin
        eg_i = i_req;
        eg_d = d_req;
      end
      e_addr = eg_i ? i_addr : (eg_d ? d_addr : last_addr);
      e_we   = eg_d && d_we && (d_addr[1:0] == 2'b00);
      @(negedge clk);
      tests++;
      if ({i_gnt, d_gnt, mem_we, mem_addr} !== {eg_i, eg_d, e_we, e_addr}) begin
        fails++; $display("FAIL rnd_gnt[%0d]: ig/dg/we %b addr %h want %b %h", n, {i_gnt, d_gnt, mem_we}, mem_addr, {eg_i, eg_d, e_we}, e_addr);
      end
      tests++;
      if ({i_ack, d_ack} !== {e_iack, e_dack}) begin
        fails++; $display("FAIL rnd_ack[%0d]: i/d ack %b want %b", n, {i_ack, d_ack}, {e_iack, e_dack});
      end
      if (e_iack) begin
        tests++;
        if ({i_err, i_rdata} !== {e_ierr, e_ird}) begin
          fails++; $display("FAIL rnd_idata[%0d]: err %b rdata %h want %b %h", n, i_err, i_rdata, e_ierr, e_ird);
        end
      end
      if (e_dack) begin
        tests++;
        if ({d_err, d_rdata} !== {e_derr, e_drd}) begin
          fails++; $display("FAIL rnd_ddata[%0d]: err %b rdata %h want %b %h", n, d_err, d_rdata, e_derr, e_drd);
        end
      end
      e_iack = eg_i;
      e_ierr = (i_addr[1:0] != 2'b00);
      e_ird  = e_ierr ? 32'd0 : ref_mem[i_addr[7:2]];
      e_dack = eg_d;
      e_derr = (d_addr[1:0] != 2'b00);
      e_drd  = e_derr ? 32'd0 : ref_mem[d_addr[7:2]];
      if (e_we) ref_mem[d_addr[7:2]] = d_wdata;
      if (eg_i) denials = 0;
      else if (i_req && denials < LIMIT) denials++;
      last_addr = e_addr;
      i_hold = i_req && !eg_i;
      d_hold = d_req && !eg_d;
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({i_ack, d_ack} !== {e_iack, e_dack}) begin
      fails++; $display("FAIL rnd_final_ack: i/d ack %b want %b", {i_ack, d_ack}, {e_iack, e_dack});
    end
    next_cycle();
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = 6'd0; bd_data = 32'd0;
    test_reset();
    preload(1'b0);
    test_fetch_stream();
    test_store_load();
    test_misaligned();
    test_conflict();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
